intt_io_ctrl: RTL and testbench
===============================

Name: intt_io_ctrl

Overview:
Frame-level I/O sequencer that wraps the INTT core. It streams one polynomial (2^NTT_LOGN coefficients, packed LANES per word) from a valid/ready input into the left/right coefficient BRAM banks, then pulses the INTT control unit's start. It waits for the transform to complete, then reads the result back out through a backpressured valid/ready output. The block owns the BRAM ports during load and unload, and hands them to the control unit in between via bram_sel.

Parameters:
COE_WIDTH, 39, coefficient width in bits
LANES, 4, coefficients per BRAM word / stream beat
NTT_LOGN, 12, log2 of polynomial length
BANK_AW, 9, bank address width; must satisfy 2^(NTT_LOGN) = LANES * 2 * 2^BANK_AW
COMMON_BRAM_DELAY, 2, BRAM read latency in cycles (rd_en to rd_data valid)
FIFO_DEPTH, 4, output skid FIFO depth; must be >= COMMON_BRAM_DELAY+2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  COE_WIDTH*LANES  packed coefficient word
cu_start  out  1  one-cycle start pulse to INTT control unit
cu_done  in  1  INTT control unit done (level; high when CU idle)
bram_sel  out  1  1 = this block drives BRAM ports; 0 = CU drives them
ld_we_l / ld_we_r  out  1 each  write enable, left/right bank
ld_addr  out  BANK_AW  write address (both banks)
ld_wdata  out  COE_WIDTH*LANES  write data (both banks)
rd_en_l / rd_en_r  out  1 each  read enable, left/right bank
rd_addr  out  BANK_AW  read address (both banks)
rd_data_l / rd_data_r  in  COE_WIDTH*LANES  bank read data, COMMON_BRAM_DELAY after rd_en
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  COE_WIDTH*LANES  result word
out_last  out  1  high on final beat (index 2*2^BANK_AW-1)
frame_done  out  1  one-cycle pulse after the last output beat is accepted

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All counters 0. FIFO empty. in_ready=1, bram_sel=1. cu_start, all we/en, out_valid, out_last, frame_done = 0. Addresses and data outputs = 0.
- Beat mapping, load and unload alike: beat index k in 0..W-1, W = 2*2^BANK_AW. Bank = k[0] (0 = left, 1 = right). Address = k[BANK_AW:1].
- FSM states: IDLE, LOAD, KICK, WAIT_LO, WAIT_HI, UNLOAD, DRAIN.
- IDLE/LOAD: in_ready=1, bram_sel=1. Each accepted beat gives a same-cycle combinational write: ld_we_{bank}=1, ld_addr, ld_wdata=in_data. Load counter increments. The first accepted beat moves IDLE to LOAD. The accepted beat with k=W-1 moves to KICK. in_valid low simply stalls; no backpressure is ever applied in these states.
- KICK: in_ready=0, bram_sel=0, cu_start=1 for exactly one cycle, then go to WAIT_LO.
- WAIT_LO: stay until cu_done=0, then go to WAIT_HI. WAIT_HI: stay until cu_done=1, then go to UNLOAD. bram_sel=0 and in_ready=0 throughout. Beats offered during KICK/WAIT/UNLOAD/DRAIN are not accepted.
- UNLOAD: bram_sel=1. Issue reads with rd_en_{bank}=1 at read counter r. Issue only when inflight + fifo_count < FIFO_DEPTH (credit rule); this guarantees no overflow under any out_ready pattern. Bank select is piped COMMON_BRAM_DELAY cycles to choose rd_data_l or rd_data_r on FIFO push. After r=W-1 is issued, go to DRAIN.
- DRAIN: no reads. Wait until inflight=0 and the last beat is popped.
- Output: FIFO head drives out_data/out_valid. A pop occurs on out_valid & out_ready, and push and pop in the same cycle are allowed. out_last is marked on the beat with k=W-1. On its acceptance, frame_done pulses for 1 cycle and the FSM returns to IDLE. IDLE can accept the next frame's beat on the following cycle.
- Latency: the first out_valid occurs COMMON_BRAM_DELAY+1 cycles after entering UNLOAD (registered FIFO output). At sustained out_ready=1, throughput is 1 beat/cycle.
- Reset mid-operation: any state returns to IDLE immediately. FIFO and counters are cleared. Partial frames are discarded.
- cu_done held high throughout WAIT_LO: stall indefinitely; there is no timeout.

Test Plan:
- Load 1024 beats with in_data=k, in_valid gaps every 3rd cycle -> writes to left addr 0..511 for even k and right addr 0..511 for odd k. Exactly 1024 we pulses. cu_start single pulse one cycle after beat 1023.
- CU model drops cu_done 1 cycle after cu_start and raises it 6143+13 cycles later -> UNLOAD starts the cycle after rise. bram_sel=0 for the entire CU window.
- Unload with out_ready=1, BRAM model returning addr*2+bank -> out_data sequence 0..1023 contiguous, out_last only on 1023, frame_done one cycle after it.
- Unload with out_ready random 30% duty, then held low 50 cycles -> no lost or duplicated beats. FIFO count never exceeds 4. Reads stall while the credit rule blocks issue.
- in_valid held high during WAIT_HI -> in_ready=0 and no writes. After frame_done, the next beat is accepted in IDLE.
- Assert rst_n=0 mid-UNLOAD at beat 300 -> all outputs return to reset values asynchronously. A fresh frame then completes correctly.

Source files
------------

// File: rtl/intt_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module : intt_io_ctrl
// Brief  : Frame sequencer around the INTT core: stream-in to BRAM banks,
//          start/wait on the control unit, then stream the result back out.
// Rev    : 1.0
// ============================================================================
module intt_io_ctrl #(
  parameter int COE_WIDTH         = 39,
  parameter int LANES             = 4,
  parameter int NTT_LOGN          = 12,
  parameter int BANK_AW           = 9,
  parameter int COMMON_BRAM_DELAY = 2,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [COE_WIDTH*LANES-1:0] in_data,
  output logic                       cu_start,
  input  logic                       cu_done,
  output logic                       bram_sel,
  output logic                       ld_we_l,
  output logic                       ld_we_r,
  output logic [BANK_AW-1:0]         ld_addr,
  output logic [COE_WIDTH*LANES-1:0] ld_wdata,
  output logic                       rd_en_l,
  output logic                       rd_en_r,
  output logic [BANK_AW-1:0]         rd_addr,
  input  logic [COE_WIDTH*LANES-1:0] rd_data_l,
  input  logic [COE_WIDTH*LANES-1:0] rd_data_r,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COE_WIDTH*LANES-1:0] out_data,
  output logic                       out_last,
  output logic                       frame_done
);

  localparam int c_dw = COE_WIDTH * LANES;
  // Beat counter spans one frame: 2^NTT_LOGN / LANES beats.
  localparam int c_cw = NTT_LOGN - $clog2(LANES);
  localparam int c_pw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_nw = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cw-1:0] c_last_beat = '1;
  localparam logic [c_nw:0]   c_depth     = (c_nw+1)'(FIFO_DEPTH);
  localparam logic [c_pw-1:0] c_ptr_max   = c_pw'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_KICK    = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_UNLOAD  = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  state_t                       r_state, w_next;
  logic [c_cw-1:0]              r_ld_cnt, r_rd_cnt;
  logic [COMMON_BRAM_DELAY-1:0] r_vpipe, r_bpipe, r_lpipe;
  logic [c_nw-1:0]              r_inflight, r_fifo_cnt;
  logic [c_pw-1:0]              r_wr_ptr, r_rd_ptr;
  logic [c_dw:0]                r_mem [FIFO_DEPTH];
  logic                         r_frame_done;

  logic            w_accept, w_issue, w_push, w_pop, w_credit_ok, w_head_last;
  logic [c_dw:0]   w_head;
  logic [c_dw-1:0] w_push_data;

  // Credit counts reads still in the BRAM pipe, so the FIFO never overflows.
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_fifo_cnt}) < c_depth;
  assign w_accept    = in_valid & in_ready;
  assign w_push      = r_vpipe[COMMON_BRAM_DELAY-1];
  assign w_push_data = r_bpipe[COMMON_BRAM_DELAY-1] ? rd_data_r : rd_data_l;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_last = w_head[c_dw];
  assign w_pop       = out_valid & out_ready;

  assign out_valid  = (r_fifo_cnt != '0);
  assign out_data   = out_valid ? w_head[c_dw-1:0] : '0;
  assign out_last   = out_valid & w_head_last;
  assign frame_done = r_frame_done;

  assign ld_we_l  = w_accept & ~r_ld_cnt[0];
  assign ld_we_r  = w_accept &  r_ld_cnt[0];
  assign ld_addr  = w_accept ? r_ld_cnt[BANK_AW:1] : '0;
  assign ld_wdata = w_accept ? in_data : '0;
  assign rd_en_l  = w_issue & ~r_rd_cnt[0];
  assign rd_en_r  = w_issue &  r_rd_cnt[0];
  assign rd_addr  = w_issue ? r_rd_cnt[BANK_AW:1] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    bram_sel = 1'b1;
    cu_start = 1'b0;
    w_issue  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = (r_ld_cnt == c_last_beat) ? S_KICK : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && r_ld_cnt == c_last_beat) w_next = S_KICK;
      end
      S_KICK: begin
        bram_sel = 1'b0;
        cu_start = 1'b1;
        w_next   = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        bram_sel = 1'b0;
        if (!cu_done) w_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        bram_sel = 1'b0;
        if (cu_done) w_next = S_UNLOAD;
      end
      S_UNLOAD: begin
        w_issue = w_credit_ok;
        if (w_credit_ok && r_rd_cnt == c_last_beat) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_vpipe      <= '0;
      r_bpipe      <= '0;
      r_lpipe      <= '0;
      r_inflight   <= '0;
      r_fifo_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_accept) r_ld_cnt <= r_ld_cnt + 1'b1;
      if (w_issue)  r_rd_cnt <= r_rd_cnt + 1'b1;

      r_vpipe[0] <= w_issue;
      r_bpipe[0] <= r_rd_cnt[0];
      r_lpipe[0] <= (r_rd_cnt == c_last_beat);
      for (int i = 1; i < COMMON_BRAM_DELAY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_bpipe[i] <= r_bpipe[i-1];
        r_lpipe[i] <= r_lpipe[i-1];
      end

      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase

      if (w_push) r_wr_ptr <= (r_wr_ptr == c_ptr_max) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_ptr_max) ? '0 : r_rd_ptr + 1'b1;

      r_frame_done <= w_pop & w_head_last;
    end
  end

  // Payload storage needs no reset: out_valid gates everything read from it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_lpipe[COMMON_BRAM_DELAY-1], w_push_data};
  end

endmodule
`default_nettype wire

// File: tb/tb_intt_io_ctrl.sv
`default_nettype none
// Testbench for intt_io_ctrl: loaded words are queued as the expected
// unload stream; a BRAM model and a simple CU handshake close the loop.
module tb_intt_io_ctrl;

  localparam int COE_WIDTH  = 39;
  localparam int LANES      = 4;
  localparam int NTT_LOGN   = 12;
  localparam int BANK_AW    = 9;
  localparam int DLY        = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int DW         = COE_WIDTH * LANES;
  localparam int W          = 2 * (2 ** BANK_AW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic cu_start;
  logic cu_done = 1'b1;
  logic bram_sel;
  logic ld_we_l, ld_we_r;
  logic [BANK_AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic rd_en_l, rd_en_r;
  logic [BANK_AW-1:0] rd_addr;
  logic [DW-1:0] rd_data_l, rd_data_r;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic out_last;
  logic frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int we_pulses = 0;
  int start_pulses = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  intt_io_ctrl #(
    .COE_WIDTH(COE_WIDTH), .LANES(LANES), .NTT_LOGN(NTT_LOGN),
    .BANK_AW(BANK_AW), .COMMON_BRAM_DELAY(DLY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cu_start(cu_start), .cu_done(cu_done), .bram_sel(bram_sel),
    .ld_we_l(ld_we_l), .ld_we_r(ld_we_r), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .rd_en_l(rd_en_l), .rd_en_r(rd_en_r), .rd_addr(rd_addr),
    .rd_data_l(rd_data_l), .rd_data_r(rd_data_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_done(frame_done)
  );

  // Two-bank BRAM model with DLY-cycle registered read latency.
  logic [DW-1:0] mem_l [2**BANK_AW];
  logic [DW-1:0] mem_r [2**BANK_AW];
  logic [DW-1:0] rl1 = '0, rl2 = '0, rr1 = '0, rr2 = '0;
  always @(posedge clk) begin
    if (bram_sel && ld_we_l) mem_l[ld_addr] <= ld_wdata;
    if (bram_sel && ld_we_r) mem_r[ld_addr] <= ld_wdata;
    if (rd_en_l) rl1 <= mem_l[rd_addr];
    if (rd_en_r) rr1 <= mem_r[rd_addr];
    rl2 <= rl1;
    rr2 <= rr1;
    if (ld_we_l || ld_we_r) we_pulses <= we_pulses + 1;
    if (cu_start) start_pulses <= start_pulses + 1;
  end
  assign rd_data_l = rl2;
  assign rd_data_r = rr2;

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if ({in_ready, bram_sel, cu_start, ld_we_l, ld_we_r, rd_en_l, rd_en_r,
         out_valid, out_last, frame_done} !== 10'b1100000000 ||
        ld_addr !== '0 || rd_addr !== '0 || ld_wdata !== '0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b sel=%b start=%b we=%b%b en=%b%b ov=%b last=%b fd=%b, required 1 1 0 00 00 0 0 0",
               in_ready, bram_sel, cu_start, ld_we_l, ld_we_r, rd_en_l, rd_en_r,
               out_valid, out_last, frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load(input bit gaps, input logic [DW-1:0] base);
    int k = 0;
    int cyc = 0;
    int we0 = we_pulses;
    logic [DW-1:0] d;
    while (k < W && cyc < 4 * W) begin
      @(negedge clk);
      d = base + DW'(k);
      in_valid = !(gaps && (cyc % 3 == 2));
      in_data = d;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || bram_sel !== 1'b1) begin
        n_errors++;
        $display("FAIL load_ready k=%0d: in_ready=%b bram_sel=%b, required 1 1", k, in_ready, bram_sel);
      end
      n_checks++;
      if (in_valid) begin
        if (ld_we_l !== !k[0] || ld_we_r !== k[0] || ld_addr !== BANK_AW'(k >> 1) || ld_wdata !== d) begin
          n_errors++;
          $display("FAIL load_write k=%0d: we_l=%b we_r=%b addr=%0d data=%0h, required %b %b %0d %0h",
                   k, ld_we_l, ld_we_r, ld_addr, ld_wdata, !k[0], k[0], k >> 1, d);
        end
        exp_q.push_back(d);
        k++;
      end else if (ld_we_l !== 1'b0 || ld_we_r !== 1'b0) begin
        n_errors++;
        $display("FAIL load_idle_write k=%0d: we_l=%b we_r=%b, required 0 0", k, ld_we_l, ld_we_r);
      end
      cyc++;
    end
    n_checks++;
    if (k != W) begin
      n_errors++;
      $display("FAIL load_timeout: beats=%0d, required %0d", k, W);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (cu_start !== 1'b1 || in_ready !== 1'b0 || bram_sel !== 1'b0) begin
      n_errors++;
      $display("FAIL kick: cu_start=%b in_ready=%b bram_sel=%b, required 1 0 0", cu_start, in_ready, bram_sel);
    end
    n_checks++;
    if (we_pulses - we0 != W) begin
      n_errors++;
      $display("FAIL load_we_count: got %0d, required %0d", we_pulses - we0, W);
    end
  endtask

  task automatic test_cu_window(input int hi_cycles, input bit hold_valid);
    int we0 = we_pulses;
    int st0 = start_pulses;
    int bad = 0;
    @(negedge clk);
    cu_done = 1'b0;
    in_valid = hold_valid;
    in_data = '1;
    #1;
    n_checks++;
    if (cu_start !== 1'b0 || bram_sel !== 1'b0) begin
      n_errors++;
      $display("FAIL cu_start_width: cu_start=%b bram_sel=%b, required 0 0", cu_start, bram_sel);
    end
    for (int i = 0; i < hi_cycles; i++) begin
      @(negedge clk);
      #1;
      if (in_ready !== 1'b0 || bram_sel !== 1'b0 || cu_start !== 1'b0 ||
          ld_we_l !== 1'b0 || ld_we_r !== 1'b0 || rd_en_l !== 1'b0 || rd_en_r !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL cu_window: %0d cycles with ready/sel/start/we/en active, required 0", bad);
    end
    @(negedge clk);
    cu_done = 1'b1;
    #1;
    n_checks++;
    if (bram_sel !== 1'b0 || start_pulses - st0 != 1 || we_pulses != we0) begin
      n_errors++;
      $display("FAIL cu_rise: bram_sel=%b starts=%0d writes=%0d, required 0 1 0",
               bram_sel, start_pulses - st0, we_pulses - we0);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_unload(input bit rand_ready, input int reset_at, input bit check_timing);
    int popped = 0;
    int issued = 0;
    int cyc = 0;
    int first_valid = -1;
    int max_out = 0;
    int low_left = 50;
    bit fd_due = 1'b0;
    bit done = 1'b0;
    logic [DW-1:0] e;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      if (rand_ready && popped >= 500 && low_left > 0) begin
        out_ready = 1'b0;
        low_left--;
      end else if (rand_ready) out_ready = ($urandom_range(0, 9) < 3);
      else out_ready = 1'b1;
      #1;
      if (reset_at >= 0 && popped == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, bram_sel, cu_start, ld_we_l, ld_we_r, rd_en_l, rd_en_r,
             out_valid, out_last, frame_done} !== 10'b1100000000 ||
            ld_addr !== '0 || rd_addr !== '0 || ld_wdata !== '0 || out_data !== '0) begin
          n_errors++;
          $display("FAIL async_reset: ready=%b sel=%b en=%b%b ov=%b data=%0h fd=%b, required 1 1 00 0 0 0",
                   in_ready, bram_sel, rd_en_l, rd_en_r, out_valid, out_data, frame_done);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        return;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      n_checks++;
      if (frame_done !== fd_due) begin
        n_errors++;
        $display("FAIL frame_done cyc=%0d: got %b, required %b", cyc, frame_done, fd_due);
      end
      if (fd_due) begin
        n_checks++;
        if (in_ready !== 1'b1 || bram_sel !== 1'b1 || out_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL back_to_idle: in_ready=%b bram_sel=%b out_valid=%b, required 1 1 0",
                   in_ready, bram_sel, out_valid);
        end
        done = 1'b1;
      end
      fd_due = 1'b0;
      if (cyc == 0) begin
        n_checks++;
        if (rd_en_l !== 1'b1) begin
          n_errors++;
          $display("FAIL unload_start: rd_en_l=%b, required 1", rd_en_l);
        end
      end
      if (rd_en_l || rd_en_r) begin
        n_checks++;
        if (issued >= W || rd_en_l !== !issued[0] || rd_en_r !== issued[0] ||
            rd_addr !== BANK_AW'(issued >> 1)) begin
          n_errors++;
          $display("FAIL read_issue n=%0d: en_l=%b en_r=%b addr=%0d, required %b %b %0d",
                   issued, rd_en_l, rd_en_r, rd_addr, !issued[0], issued[0], issued >> 1);
        end
        issued++;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (out_data !== e || out_last !== (popped == W - 1)) begin
          n_errors++;
          $display("FAIL out_beat n=%0d: data=%0h last=%b, required %0h %b",
                   popped, out_data, out_last, e, popped == W - 1);
        end
        if (popped == W - 1) fd_due = 1'b1;
        popped++;
      end
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (!done || popped != W || issued != W || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL unload_complete: done=%b popped=%0d issued=%0d left=%0d, required 1 %0d %0d 0",
               done, popped, issued, exp_q.size(), W, W);
    end
    n_checks++;
    if (max_out > FIFO_DEPTH || (rand_ready && low_left == 0 && max_out != FIFO_DEPTH)) begin
      n_errors++;
      $display("FAIL credit: max outstanding=%0d, required <=%0d (==%0d after stall)",
               max_out, FIFO_DEPTH, FIFO_DEPTH);
    end
    if (check_timing) begin
      n_checks++;
      if (first_valid != DLY + 1 || cyc != DLY + 2 + W) begin
        n_errors++;
        $display("FAIL unload_timing: first_valid=%0d end=%0d, required %0d %0d",
                 first_valid, cyc, DLY + 1, DLY + 2 + W);
      end
    end
  endtask

  function automatic logic [DW-1:0] rand_base();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic test_load_gaps_full_cu();
    test_load(1'b1, '0);
    test_cu_window(6156, 1'b1);
    test_unload(1'b0, -1, 1'b1);
  endtask

  task automatic test_random_ready();
    test_load(1'b0, rand_base());
    test_cu_window(20, 1'b0);
    test_unload(1'b1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_unload();
    test_load(1'b0, rand_base());
    test_cu_window(10, 1'b0);
    test_unload(1'b1, 300, 1'b0);
    test_load(1'b1, rand_base());
    test_cu_window(15, 1'b1);
    test_unload(1'b0, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_load_gaps_full_cu();
    test_random_ready();
    test_reset_mid_unload();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
